// File: rtl/jtcps1_obj_line_buf.sv
// Ping-pong object line buffer between the object draw engine and the colour mixer.
// The draw engine fills the write bank while the read bank streams to the mixer and is erased behind the read.
// Ports: rst/clk (async active-high reset), pxl_cen (pixel enable), start (line start, swaps banks),
//        buf_addr/buf_data/buf_wr (draw engine write), hdump (read address), pxl (object pixel),
//        init_busy (post-reset clear sweep running).
// Option: JTCPS1_OBJ_FIRST_WINS_EN turns writes into read-modify-write so the first opaque pixel wins.
module jtcps1_obj_line_buf #(
    parameter int            AW    = 9,
    parameter int            DW    = 9,
    parameter logic [DW-1:0] BLANK = 9'h1FF
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          pxl_cen,
    input  logic          start,
    input  logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_data,
    input  logic          buf_wr,
    input  logic [AW-1:0] hdump,
    output logic [DW-1:0] pxl,
    output logic          init_busy
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] ra;
    logic          ra_bank;
    logic          rd_pend;
    logic          wr_bank;
    logic [DW-1:0] rd_a, rd_b;
    logic [DW-1:0] ram_a [2**AW];
    logic [DW-1:0] ram_b [2**AW];

    // Unified write port into the draw-side bank
    logic          we;
    logic          wbank;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    wire opaque = buf_data[3:0] != 4'hF;

`ifdef JTCPS1_OBJ_FIRST_WINS_EN
    logic          pend;
    logic          pb;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [DW-1:0] pq;
    logic          fwd;

    // Commit only onto a still-transparent location
    always_comb begin
        we    = state == RUN && pend && pq[3:0] == 4'hF;
        wbank = pb;
        waddr = pa;
        wdata = pd;
        fwd   = we && pa == buf_addr && pb == wr_bank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            pb   <= 1'b0;
            pa   <= '0;
            pd   <= BLANK;
        end else begin
            pend <= state == RUN && buf_wr && opaque;
            if (buf_wr) begin
                pb <= wr_bank;
                pa <= buf_addr;
                pd <= buf_data;
            end
        end
    end

    // Stored value for the check, with the in-flight commit forwarded
    always_ff @(posedge clk) begin
        if (fwd)
            pq <= pd;
        else if (wr_bank)
            pq <= ram_b[buf_addr];
        else
            pq <= ram_a[buf_addr];
    end
`else
    always_comb begin
        we    = state == RUN && buf_wr && opaque;
        wbank = wr_bank;
        waddr = buf_addr;
        wdata = buf_data;
    end
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: if (cnt == {AW{1'b1}}) state_nx = RUN;
            RUN:  state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_busy <= 1'b1;
            cnt       <= '0;
            wr_bank   <= 1'b0;
            ra        <= '0;
            ra_bank   <= 1'b0;
            rd_pend   <= 1'b0;
            pxl       <= BLANK;
        end else begin
            state     <= state_nx;
            init_busy <= state_nx == INIT;
            if (start) wr_bank <= ~wr_bank;
            if (state == INIT) begin
                cnt     <= cnt + 1'b1;
                rd_pend <= 1'b0;
                pxl     <= BLANK;
            end else begin
                rd_pend <= pxl_cen;
                if (pxl_cen) begin
                    ra      <= hdump;
                    ra_bank <= ~wr_bank;
                end
                if (rd_pend) pxl <= ra_bank ? rd_b : rd_a;
            end
        end
    end

    // Storage: no reset, cleared by the INIT sweep.
    // Read ports forward a same-cycle write so a fresh pixel is never missed.
    always_ff @(posedge clk) begin
        rd_a <= (we && !wbank && waddr == hdump) ? wdata : ram_a[hdump];
        rd_b <= (we &&  wbank && waddr == hdump) ? wdata : ram_b[hdump];
        if (state == INIT) begin
            ram_a[cnt] <= BLANK;
            ram_b[cnt] <= BLANK;
        end else begin
            // Erase first so a same-address draw write wins
            if (rd_pend) begin
                if (ra_bank) ram_b[ra] <= BLANK;
                else         ram_a[ra] <= BLANK;
            end
            if (we) begin
                if (wbank) ram_b[waddr] <= wdata;
                else       ram_a[waddr] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_obj_line_buf.sv
// Self-checking bench for jtcps1_obj_line_buf.
// Directed cases plus random draw/swap/read traffic against an array model of both banks.
module tb_jtcps1_obj_line_buf;

    localparam logic [8:0] BLANK = 9'h1FF;

    logic       rst, clk, pxl_cen, start, buf_wr, init_busy;
    logic [8:0] buf_addr, buf_data, hdump, pxl;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] mb [2][512];
    bit         mwb;

    jtcps1_obj_line_buf dut (
        .rst       (rst),
        .clk       (clk),
        .pxl_cen   (pxl_cen),
        .start     (start),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_wr    (buf_wr),
        .hdump     (hdump),
        .pxl       (pxl),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 512; a++) mb[b][a] = BLANK;
        mwb = 1'b0;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (init_busy && n < 600) begin
            tick();
            n++;
        end
        check("init_len", n, 512);
    endtask

    // Draw a pixel, optionally together with a line start
    task automatic wr(input logic [8:0] a, input logic [8:0] d, input bit sw);
        buf_addr = a;
        buf_data = d;
        buf_wr   = 1'b1;
        start    = sw;
        tick();
        buf_wr = 1'b0;
        start  = 1'b0;
`ifdef JTCPS1_OBJ_FIRST_WINS_EN
        if (d[3:0] != 4'hF && mb[mwb][a][3:0] == 4'hF) mb[mwb][a] = d;
`else
        if (d[3:0] != 4'hF) mb[mwb][a] = d;
`endif
        if (sw) mwb = ~mwb;
    endtask

    task automatic swap();
        start = 1'b1;
        tick();
        start = 1'b0;
        mwb = ~mwb;
    endtask

    // Read one pixel from the display bank; it is erased behind the read
    task automatic rd(input string tag, input logic [8:0] a, input bit sw);
        logic [8:0] e;
        e = mb[!mwb][a];
        mb[!mwb][a] = BLANK;
        hdump   = a;
        pxl_cen = 1'b1;
        start   = sw;
        tick();
        pxl_cen = 1'b0;
        start   = 1'b0;
        if (sw) mwb = ~mwb;
        tick();
        check(tag, pxl, e);
    endtask

    initial begin
        int op;
        rst = 1'b1; pxl_cen = 0; start = 0; buf_wr = 0;
        buf_addr = 0; buf_data = 0; hdump = 0;
        model_clear();
        #1;
        check("rst_busy", init_busy, 1);
        check("rst_pxl", pxl, BLANK);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init();
        check("busy_low", init_busy, 0);

        // Whole buffer cleared, both banks
        for (int b = 0; b < 2; b++) begin
            swap();
            for (int a = 0; a < 512; a++) rd("clear", a[8:0], 0);
        end

        // Draw then display, then erased
        wr(10, 9'h0A3, 0);
        swap();
        rd("draw", 10, 0);
        tick();
        check("hold", pxl, 9'h0A3);
        swap();
        swap();
        rd("erased", 10, 0);

        // Transparent write dropped
        wr(20, 9'h045, 0);
        wr(20, 9'h07F, 0);
        swap();
        rd("transp", 20, 0);

        // Overwrite order
        wr(30, 9'h045, 0);
        wr(30, 9'h132, 0);
        swap();
        rd("overwr", 30, 0);

        // Write in the start cycle lands in the old bank
        wr(5, 9'h011, 1);
        rd("wr_start", 5, 0);

        // Address boundary
        wr(511, 9'h155, 0);
        wr(0, 9'h0E2, 0);
        swap();
        rd("a511", 511, 0);
        rd("a0", 0, 0);

        // Read in the start cycle uses the old read bank
        wr(7, 9'h066, 0);
        swap();
        wr(7, 9'h0B4, 0);
        rd("rd_start", 7, 1);
        rd("rd_start2", 7, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(9);
            if (op <= 4)
                wr($urandom_range(15), $urandom_range(511), 0);
            else if (op == 5)
                wr($urandom_range(15), $urandom_range(511), 1);
            else if (op == 6)
                swap();
            else
                rd("rand", $urandom_range(15), op == 9);
        end

        // Reset mid-line
        wr(100, 9'h0C1, 0);
        swap();
        rd("pre_rst", 100, 0);
        wr(100, 9'h0C1, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pxl", pxl, BLANK);
        check("mid_rst_busy", init_busy, 1);
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        wait_init();
        rd("post_rst0", 100, 0);
        swap();
        rd("post_rst1", 100, 0);
        swap();
        rd("post_rst2", 100, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
